// File: rtl/ysyx_24110015_lsu.sv
// ysyx_24110015_lsu: load/store unit between the execute and write-back stages.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses without a bus request.
module ysyx_24110015_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        processing,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] alu_out_i,
    input  logic        RegWrite_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [2:0]  func3_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        ebreak_i,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        RegWrite_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data,
    output logic        ebreak_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        req_valid_q, req_valid_d;
    logic        out_valid_q, out_valid_d;
    logic        processing_q, processing_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        ebreak_q, ebreak_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [2:0]  func3_q, func3_d;
    logic        mem_read_q, mem_read_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_wen_q, req_wen_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;

    logic        is_mem;
    logic        misalign;
    logic [31:0] load_sh;
    logic [31:0] load_data;

    assign is_mem = MemRead_i | MemWrite_i;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = is_mem &&
                      ((func3_i[1:0] == 2'b01 && alu_out_i[0]) ||
                       (func3_i[1:0] == 2'b10 && alu_out_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign load_sh = rsp_rdata >> {off_q, 3'b000};

    always_comb begin
        load_data = '0;
        case (func3_q)
            3'b000:  load_data = {{24{load_sh[7]}}, load_sh[7:0]};
            3'b001:  load_data = {{16{load_sh[15]}}, load_sh[15:0]};
            3'b010:  load_data = load_sh;
            3'b100:  load_data = {24'h000000, load_sh[7:0]};
            3'b101:  load_data = {16'h0000, load_sh[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        misalign_d  = misalign_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        reg_write_d = reg_write_q;
        wb_addr_d   = wb_addr_q;
        ebreak_d    = ebreak_q;
        wb_data_d   = wb_data_q;
        func3_d     = func3_q;
        mem_read_d  = mem_read_q;
        off_d       = off_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pc_d        = pc_i;
                    inst_d      = inst_i;
                    reg_write_d = RegWrite_i;
                    wb_addr_d   = wb_addr_i;
                    ebreak_d    = ebreak_i;
                    func3_d     = func3_i;
                    mem_read_d  = MemRead_i;
                    off_d       = alu_out_i[1:0];
                    misalign_d  = misalign;
                    wb_data_d   = misalign ? '0 : alu_out_i;
                    // Alignment is done once at accept so the bus fields are plain flops.
                    req_addr_d  = {alu_out_i[31:2], 2'b00};
                    req_wen_d   = MemWrite_i;
                    req_wdata_d = mem_wdata_i << {alu_out_i[1:0], 3'b000};
                    req_wstrb_d = mem_wmask_i << alu_out_i[1:0];
                    state_d     = (is_mem && !misalign) ? REQ : DONE;
                end
            end
            REQ: begin
                if (req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (rsp_valid) begin
                    state_d = DONE;
                    if (mem_read_q) wb_data_d = load_data;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d   = (state_d == IDLE);
        req_valid_d  = (state_d == REQ);
        out_valid_d  = (state_d == DONE);
        processing_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            req_valid_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            processing_q <= 1'b0;
            misalign_q   <= 1'b0;
            pc_q         <= '0;
            inst_q       <= '0;
            reg_write_q  <= 1'b0;
            wb_addr_q    <= '0;
            ebreak_q     <= 1'b0;
            wb_data_q    <= '0;
            func3_q      <= '0;
            mem_read_q   <= 1'b0;
            off_q        <= '0;
            req_addr_q   <= '0;
            req_wen_q    <= 1'b0;
            req_wdata_q  <= '0;
            req_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            req_valid_q  <= req_valid_d;
            out_valid_q  <= out_valid_d;
            processing_q <= processing_d;
            misalign_q   <= misalign_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            reg_write_q  <= reg_write_d;
            wb_addr_q    <= wb_addr_d;
            ebreak_q     <= ebreak_d;
            wb_data_q    <= wb_data_d;
            func3_q      <= func3_d;
            mem_read_q   <= mem_read_d;
            off_q        <= off_d;
            req_addr_q   <= req_addr_d;
            req_wen_q    <= req_wen_d;
            req_wdata_q  <= req_wdata_d;
            req_wstrb_q  <= req_wstrb_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign req_valid  = req_valid_q;
    assign out_valid  = out_valid_q;
    assign processing = processing_q;
    assign misalign_o = misalign_q;
    assign pc_o       = pc_q;
    assign inst_o     = inst_q;
    assign RegWrite_o = reg_write_q;
    assign wb_addr_o  = wb_addr_q;
    assign ebreak_o   = ebreak_q;
    assign wb_data    = wb_data_q;
    assign req_addr   = req_addr_q;
    assign req_wen    = req_wen_q;
    assign req_wdata  = req_wdata_q;
    assign req_wstrb  = req_wstrb_q;

endmodule
